// File: rtl/fp_pkg.sv
// Shared types for the single-precision add/sub operand-alignment block.
// Holds the format widths, the unpacked operand view and the special-result classes.
// The classify/unpack helpers are pure functions that turn directly into logic.
package fp_pkg;

  localparam int M    = 24;   // mantissa width including hidden bit
  localparam int E    = 8;    // exponent width
  localparam int BIAS = 127;  // single-precision exponent bias

  typedef struct packed {
    logic         sign;
    logic [E-1:0] exp;
    logic [M-1:0] mant;
  } fp_op_t;

  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO   = 2'b01,
    SP_INF    = 2'b10,
    SP_NAN    = 2'b11
  } special_e;

  // Denormals get hidden bit 0 and effective exponent 1 so they line up with the smallest normals.
  function automatic fp_op_t fp_unpack(input logic [31:0] f, input logic flip);
    fp_op_t r;
    r.sign = f[31] ^ flip;
    r.exp  = (f[30:23] == 8'd0) ? 8'd1 : f[30:23];
    r.mant = {(f[30:23] != 8'd0), f[22:0]};
    return r;
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] f);
    return (&f[30:23]) && (|f[22:0]);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] f);
    return (&f[30:23]) && !(|f[22:0]);
  endfunction

  function automatic logic fp_is_zero(input logic [31:0] f);
    return (f[30:0] == 31'd0);
  endfunction

endpackage

// File: rtl/fp_add_align_if.sv
// Operand-in / aligned-result-out bundle for fp_add_align.
// Carries both valid/ready channels; no storage of its own.
// slave is the alignment stage's view, master is the producer/consumer view.
interface fp_add_align_if #(
  parameter int M = 24,
  parameter int E = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  a;
  logic [31:0]  b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] mant_x;
  logic [M-1:0] mant_y;
  logic [2:0]   grs;
  logic         sub;
  logic [E-1:0] exp;
  logic         sign;
  logic [1:0]   special;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, mant_x, mant_y, grs, sub, exp, sign, special
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, mant_x, mant_y, grs, sub, exp, sign, special
  );
endinterface

// File: rtl/fp_rshift_sticky.sv
// Right-shifts the smaller mantissa and collects guard/round/sticky from the bits shifted out.
// Purely combinational, zero latency.
// No handshake; caller registers the result.
module fp_rshift_sticky #(
  parameter int M  = 24,
  parameter int SW = 8
) (
  input  logic [M-1:0]  din,
  input  logic [SW-1:0] shamt,
  output logic [M-1:0]  dout,
  output logic [2:0]    grs
);

  // Beyond M+2 every mantissa bit lands in sticky, so the wide shifter only needs M+2 extra bits.
  localparam int LIM = M + 2;

  logic [M+LIM-1:0] ext;

  // Shift mantissa into an extended field; the low half holds guard, round and sticky sources.
  always_comb begin
    ext  = {din, {LIM{1'b0}}} >> shamt;
    dout = ext[M+LIM-1:LIM];
    grs  = {ext[LIM-1], ext[LIM-2], |ext[LIM-3:0]};
    if (shamt > SW'(LIM)) begin
      dout = '0;
      grs  = {2'b00, |din};
    end
  end

endmodule

// File: rtl/fp_add_align.sv
// IEEE-754 single add/sub front end: unpack, order by magnitude, align smaller mantissa with GRS.
// Latency 2 cycles (S1 unpack/compare/swap, S2 shift/sticky), one operand pair per cycle.
// Stalls propagate back through S2 then S1; outputs hold while out_valid && !out_ready.
module fp_add_align #(
  parameter int M = fp_pkg::M,
  parameter int E = fp_pkg::E
) (
  input logic          clk,
  input logic          rst_n,
  fp_add_align_if.slave io
);
  import fp_pkg::*;

  fp_op_t       ua, ub, x, y;
  logic         a_ge_b;
  logic         sub_c;
  logic [E-1:0] d_c;
  special_e     spec_c;

  logic         s1_vld;
  fp_op_t       s1_x;
  logic [M-1:0] s1_ymant;
  logic [E-1:0] s1_d;
  logic         s1_sub;
  special_e     s1_spec;

  logic         s2_vld;
  logic [M-1:0] s2_mant_x;
  logic [M-1:0] s2_mant_y;
  logic [2:0]   s2_grs;
  logic         s2_sub;
  logic [E-1:0] s2_exp;
  logic         s2_sign;
  special_e     s2_spec;

  logic         s1_load, s2_load;
  logic [M-1:0] sh_mant;
  logic [2:0]   sh_grs;

  assign s2_load     = !s2_vld || io.out_ready;
  assign s1_load     = !s1_vld || s2_load;
  assign io.in_ready = s1_load;

  // S1 datapath: unpack both operands, pick the larger magnitude (tie keeps a), classify specials.
  always_comb begin
    ua     = fp_unpack(io.a, 1'b0);
    ub     = fp_unpack(io.b, io.op);
    a_ge_b = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
    x      = a_ge_b ? ua : ub;
    y      = a_ge_b ? ub : ua;
    sub_c  = io.a[31] ^ io.b[31] ^ io.op;
    d_c    = x.exp - y.exp;
    spec_c = SP_NORMAL;
    if (fp_is_nan(io.a) || fp_is_nan(io.b))
      spec_c = SP_NAN;
    else if (fp_is_inf(io.a) && fp_is_inf(io.b))
      spec_c = sub_c ? SP_NAN : SP_INF;
    else if (fp_is_inf(io.a) || fp_is_inf(io.b))
      spec_c = SP_INF;
    else if (fp_is_zero(io.a) && fp_is_zero(io.b))
      spec_c = SP_ZERO;
    // Special results carry zeroed mantissas so the downstream adder sees deterministic data.
    if (spec_c != SP_NORMAL) begin
      x.mant = '0;
      y.mant = '0;
    end
  end

  // S1 register: capture the ordered operands whenever this stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_x     <= '0;
      s1_ymant <= '0;
      s1_d     <= '0;
      s1_sub   <= 1'b0;
      s1_spec  <= SP_NORMAL;
    end else if (s1_load) begin
      s1_vld <= io.in_valid;
      if (io.in_valid) begin
        s1_x     <= x;
        s1_ymant <= y.mant;
        s1_d     <= d_c;
        s1_sub   <= sub_c;
        s1_spec  <= spec_c;
      end
    end
  end

  fp_rshift_sticky #(.M(M), .SW(E)) u_shift (
    .din   (s1_ymant),
    .shamt (s1_d),
    .dout  (sh_mant),
    .grs   (sh_grs)
  );

  // S2 register: aligned result; frozen while the downstream adder is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld    <= 1'b0;
      s2_mant_x <= '0;
      s2_mant_y <= '0;
      s2_grs    <= '0;
      s2_sub    <= 1'b0;
      s2_exp    <= '0;
      s2_sign   <= 1'b0;
      s2_spec   <= SP_NORMAL;
    end else if (s2_load) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_mant_x <= s1_x.mant;
        s2_mant_y <= sh_mant;
        s2_grs    <= sh_grs;
        s2_sub    <= s1_sub;
        s2_exp    <= s1_x.exp;
        s2_sign   <= s1_x.sign;
        s2_spec   <= s1_spec;
      end
    end
  end

  assign io.out_valid = s2_vld;
  assign io.mant_x    = s2_mant_x;
  assign io.mant_y    = s2_mant_y;
  assign io.grs       = s2_grs;
  assign io.sub       = s2_sub;
  assign io.exp       = s2_exp;
  assign io.sign      = s2_sign;
  assign io.special   = s2_spec;

endmodule

// File: tb/tb_fp_add_align.sv
module tb_fp_add_align;

  typedef struct packed {
    logic [23:0] mant_x;
    logic [23:0] mant_y;
    logic [2:0]  grs;
    logic        sub;
    logic [7:0]  exp;
    logic        sign;
    logic [1:0]  special;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    res_t        want;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_add_align_if io ();
  fp_add_align dut (.clk(clk), .rst_n(rst_n), .io(io));

  int   checks = 0;
  int   errors = 0;
  res_t sbq[$];
  logic sb_en = 1'b0;
  res_t snap, prev_snap;
  logic fired_out = 1'b0;
  logic prev_stall = 1'b0;
  int   n_tx = 0;
  int   n_rx = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic cmp_res(input string nm, input res_t got, input res_t want);
    chk({nm, ".mant_x"},  32'(got.mant_x),  32'(want.mant_x));
    chk({nm, ".mant_y"},  32'(got.mant_y),  32'(want.mant_y));
    chk({nm, ".grs"},     32'(got.grs),     32'(want.grs));
    chk({nm, ".sub"},     32'(got.sub),     32'(want.sub));
    chk({nm, ".exp"},     32'(got.exp),     32'(want.exp));
    chk({nm, ".sign"},    32'(got.sign),    32'(want.sign));
    chk({nm, ".special"}, 32'(got.special), 32'(want.special));
  endtask

  // Reference: magnitudes as plain integers, GRS taken bit by bit from the rule definitions.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    res_t   r;
    int     ea, eb, ex, ey, d, sp;
    longint ma, mb, mx, my;
    logic   sa, sb, sx, g, rd, st;
    logic   nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    sa = a[31];
    sb = b[31] ^ op;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    if (ea == 0) ea = 1; else ma = ma + 64'd8388608;
    if (eb == 0) eb = 1; else mb = mb + 64'd8388608;
    if (longint'(ea) * 16777216 + ma >= longint'(eb) * 16777216 + mb) begin
      ex = ea; mx = ma; sx = sa; ey = eb; my = mb;
    end else begin
      ex = eb; mx = mb; sx = sb; ey = ea; my = ma;
    end
    d = ex - ey;
    r = '0;
    r.sub  = a[31] ^ b[31] ^ op;
    r.sign = sx;
    r.exp  = 8'(ex);
    nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    zero_a = (a[30:0] == 0);
    zero_b = (b[30:0] == 0);
    if (nan_a || nan_b) sp = 3;
    else if (inf_a && inf_b) sp = r.sub ? 3 : 2;
    else if (inf_a || inf_b) sp = 2;
    else if (zero_a && zero_b) sp = 1;
    else sp = 0;
    r.special = 2'(sp);
    if (sp == 0) begin
      r.mant_x = 24'(mx);
      if (d <= 26) begin
        r.mant_y = 24'(my >> d);
        g  = (d >= 1) ? my[d-1] : 1'b0;
        rd = (d >= 2) ? my[d-2] : 1'b0;
        st = (d >= 3) ? ((my & ((64'd1 << (d - 2)) - 1)) != 0) : 1'b0;
      end else begin
        r.mant_y = 24'd0;
        g  = 1'b0;
        rd = 1'b0;
        st = (my != 0);
      end
      r.grs = {g, rd, st};
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                              input logic [23:0] mx, input logic [23:0] my, input logic [2:0] grs,
                              input logic sub, input logic [7:0] ex, input logic sign,
                              input logic [1:0] sp);
    vec_t v;
    v.a = a; v.b = b; v.op = op;
    v.want.mant_x = mx; v.want.mant_y = my; v.want.grs = grs; v.want.sub = sub;
    v.want.exp = ex; v.want.sign = sign; v.want.special = sp;
    return v;
  endfunction

  function automatic logic [31:0] rnd_fp(input int base);
    logic [31:0] f;
    int          cls, e;
    cls      = int'($urandom_range(0, 15));
    f[31]    = 1'($urandom_range(0, 1));
    f[22:0]  = 23'($urandom);
    case (cls)
      0:       begin f[30:23] = 8'h00; f[22:0] = 23'd0; end
      1:       begin f[30:23] = 8'hFF; f[22:0] = 23'd0; end
      2:       begin f[30:23] = 8'hFF; f[22] = 1'b1; end
      3:       f[30:23] = 8'h00;
      default: begin
        e = base + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        f[30:23] = 8'(e);
      end
    endcase
    return f;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.mant_x = io.mant_x; r.mant_y = io.mant_y; r.grs = io.grs; r.sub = io.sub;
    r.exp = io.exp; r.sign = io.sign; r.special = io.special;
    return r;
  endfunction

  // One clock: drive after the falling edge, sample 1 time unit later, score transfers.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic ordy, output logic fired_in);
    res_t w;
    @(negedge clk);
    io.in_valid = iv; io.a = a; io.b = b; io.op = op; io.out_ready = ordy;
    #1;
    snap      = sample();
    fired_in  = io.in_valid && io.in_ready;
    fired_out = io.out_valid && io.out_ready;
    if (sb_en) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(io.out_valid), 32'd1);
        cmp_res("hold", snap, prev_snap);
      end
      if (fired_in) begin
        sbq.push_back(model(a, b, op));
        n_tx++;
      end
      if (fired_out) begin
        n_rx++;
        if (sbq.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          w = sbq.pop_front();
          cmp_res("stream", snap, w);
        end
      end
    end
    prev_stall = io.out_valid && !io.out_ready;
    prev_snap  = snap;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[16];
    logic        fi, pending, cop;
    logic [31:0] ca, cb;
    int          lat, k, sent, stale;

    tbl[0]  = mk(32'h3F800000, 32'h40000000, 1'b0, 24'h800000, 24'h400000, 3'b000, 1'b0, 8'h80, 1'b0, 2'b00);
    tbl[1]  = mk(32'h3F800000, 32'h3F800000, 1'b1, 24'h800000, 24'h800000, 3'b000, 1'b1, 8'h7F, 1'b0, 2'b00);
    tbl[2]  = mk(32'h4B800000, 32'h3F800001, 1'b0, 24'h800000, 24'h000000, 3'b101, 1'b0, 8'h97, 1'b0, 2'b00);
    tbl[3]  = mk(32'h7F800000, 32'hFF800000, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b1, 8'hFF, 1'b0, 2'b11);
    tbl[4]  = mk(32'h7F800000, 32'hFF800000, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 8'hFF, 1'b0, 2'b10);
    tbl[5]  = mk(32'h00000000, 32'h80000000, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b1, 8'h01, 1'b0, 2'b01);
    tbl[6]  = mk(32'h7FC00000, 32'h3F800000, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 8'hFF, 1'b0, 2'b11);
    tbl[7]  = mk(32'h00000001, 32'h00000003, 1'b0, 24'h000003, 24'h000001, 3'b000, 1'b0, 8'h01, 1'b0, 2'b00);
    tbl[8]  = mk(32'h4E800000, 32'hBF800001, 1'b0, 24'h800000, 24'h000000, 3'b001, 1'b1, 8'h9D, 1'b0, 2'b00);
    tbl[9]  = mk(32'h3F800000, 32'hC0400000, 1'b1, 24'hC00000, 24'h400000, 3'b000, 1'b0, 8'h80, 1'b0, 2'b00);
    tbl[10] = mk(32'hC0A00000, 32'h3F400001, 1'b0, 24'hA00000, 24'h180000, 3'b001, 1'b1, 8'h81, 1'b1, 2'b00);
    tbl[11] = mk(32'h7F800000, 32'h3F800000, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b1, 8'hFF, 1'b0, 2'b10);
    tbl[12] = mk(32'h4C800000, 32'h3FFFFFFF, 1'b0, 24'h800000, 24'h000000, 3'b001, 1'b0, 8'h99, 1'b0, 2'b00);
    tbl[13] = mk(32'h4C000000, 32'h3FFFFFFF, 1'b0, 24'h800000, 24'h000000, 3'b011, 1'b0, 8'h98, 1'b0, 2'b00);
    tbl[14] = mk(32'h00400000, 32'h3F800000, 1'b0, 24'h800000, 24'h000000, 3'b001, 1'b0, 8'h7F, 1'b0, 2'b00);
    tbl[15] = mk(32'h80000000, 32'h3F800000, 1'b1, 24'h800000, 24'h000000, 3'b000, 1'b0, 8'h7F, 1'b1, 2'b00);

    // Reset state
    rst_n = 1'b0;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.op = 1'b0; io.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_in_ready",  32'(io.in_ready),  32'd1);
    chk("rst_mant_x",    32'(io.mant_x),    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(io.in_ready), 32'd1);

    // Directed vectors, one at a time, latency measured on each
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1, fi);
      chk($sformatf("v%0d.accept", i), 32'(fi), 32'd1);
      lat = 0;
      fired_out = 1'b0;
      while (!fired_out && lat < 8) begin
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fi);
        lat++;
      end
      chk($sformatf("v%0d.latency", i), 32'(lat), 32'd2);
      cmp_res($sformatf("v%0d", i), snap, tbl[i].want);
    end

    // Back-to-back 8 with out_ready 1,0,0 repeating, scored against the model
    sb_en = 1'b1; prev_stall = 1'b0; sbq.delete(); n_tx = 0; n_rx = 0;
    pending = 1'b0; sent = 0; k = 0; ca = '0; cb = '0; cop = 1'b0;
    while (sent < 8 && k < 200) begin
      if (!pending) begin
        ca = rnd_fp(int'($urandom_range(1, 254)));
        cb = rnd_fp(int'(ca[30:23]));
        cop = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      cycle(1'b1, ca, cb, cop, (k % 3) == 0, fi);
      if (fi) begin pending = 1'b0; sent++; end
      k++;
    end
    chk("b2b_sent", 32'(sent), 32'd8);

    // Random traffic with random backpressure
    sent = 0; k = 0;
    while (sent < 300 && k < 5000) begin
      if (!pending && $urandom_range(0, 9) < 7) begin
        ca = rnd_fp(int'($urandom_range(1, 254)));
        cb = rnd_fp(int'(ca[30:23]));
        cop = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      cycle(pending, ca, cb, cop, $urandom_range(0, 9) < 6, fi);
      if (fi) begin pending = 1'b0; sent++; end
      k++;
    end
    k = 0;
    while (sbq.size() > 0 && k < 100) begin
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fi);
      k++;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    chk("tx_rx_count", 32'(n_rx), 32'(n_tx));

    // Asynchronous reset with both stages full
    sb_en = 1'b0;
    cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, fi);
    cycle(1'b1, 32'h40400000, 32'h3F800000, 1'b0, 1'b0, fi);
    cycle(1'b1, 32'h40800000, 32'h3F800000, 1'b0, 1'b0, fi);
    chk("full_out_valid", 32'(io.out_valid), 32'd1);
    chk("full_in_ready",  32'(io.in_ready),  32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    #1;
    chk("arst_out_valid", 32'(io.out_valid), 32'd0);
    chk("arst_in_ready",  32'(io.in_ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fi);
      if (fired_out) stale++;
    end
    chk("no_stale_out", 32'(stale), 32'd0);

    // One scored transaction after reset recovery
    sb_en = 1'b1; prev_stall = 1'b0; sbq.delete(); n_tx = 0; n_rx = 0;
    cycle(1'b1, 32'h41200000, 32'hBE000001, 1'b1, 1'b1, fi);
    k = 0;
    while (sbq.size() > 0 && k < 20) begin
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fi);
      k++;
    end
    chk("post_rst_drain", 32'(sbq.size()), 32'd0);
    chk("post_rst_rx", 32'(n_rx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
